// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the tone generator and its note sources.
package tone_gen_pkg;

    localparam int unsigned DIV_W_DEF    = 20;
    localparam int unsigned MIN_DIV      = 16;
    localparam int unsigned HOLD_CYC_DEF = 25_000_000;

    // Half-period divisors at 50 MHz (clk / (2 * f_note)).
    localparam int unsigned NOTE_DIV_C4 = 95_557;
    localparam int unsigned NOTE_DIV_D4 = 85_131;
    localparam int unsigned NOTE_DIV_E4 = 75_843;
    localparam int unsigned NOTE_DIV_F4 = 71_586;
    localparam int unsigned NOTE_DIV_G4 = 63_776;
    localparam int unsigned NOTE_DIV_A4 = 56_818;
    localparam int unsigned NOTE_DIV_B4 = 50_619;
    localparam int unsigned NOTE_DIV_C5 = 47_778;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } tone_state_e;

endpackage

// File: rtl/tone_half_period_ctr.sv
// Half-period counter: counts 0..div-1 and flags the terminal cycle.
module tone_half_period_ctr
    import tone_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_term_c
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    assign w_last   = i_div - DIV_W'(1);
    assign o_term_c = i_run && (r_cnt == w_last);

    // Count while running; wrap to zero at terminal, hold at zero when idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || o_term_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with phase-continuous note changes.
// Optional: define TONE_AUTO_RELEASE_EN to add a HOLD_CYC auto-release timer.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
`ifdef TONE_AUTO_RELEASE_EN
    ,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_note_div,
    input  logic             i_note_valid,
    input  logic             i_note_off,
    output logic             o_spk,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_cur_div
);

    tone_state_e      r_state;
    tone_state_e      w_state_nxt;
    logic             r_spk;
    logic             r_busy;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             w_spk_nxt;
    logic [DIV_W-1:0] w_cur_div_nxt;
    logic [DIV_W-1:0] w_pend_div_nxt;
    logic             w_term;
    logic             w_low;
    logic             w_valid;
    logic             w_off;
    logic             w_expire;

    assign w_low   = i_note_div < DIV_W'(MIN_DIV);
    assign w_valid = i_note_valid && !i_note_off && !w_low;
    assign w_off   = i_note_off || (i_note_valid && w_low) || w_expire;

    tone_half_period_ctr #(
        .DIV_W (DIV_W)
    ) u_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (r_state != IDLE),
        .i_div    (r_cur_div),
        .o_term_c (w_term)
    );

`ifdef TONE_AUTO_RELEASE_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    logic [HOLD_W-1:0] r_hold;

    // Hold timer: restarts on every accepted note, saturates at expiry, zero when idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold <= '0;
        end else if (w_valid) begin
            r_hold <= HOLD_W'(1);
        end else if (r_state == IDLE) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_W'(HOLD_CYC - 1)) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    assign w_expire = !w_valid && ((r_state == PLAY) || (r_state == PEND))
                      && (r_hold == HOLD_W'(HOLD_CYC - 1));
`else
    assign w_expire = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_spk      <= 1'b0;
            r_busy     <= 1'b0;
            r_cur_div  <= '0;
            r_pend_div <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_spk      <= w_spk_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_cur_div  <= w_cur_div_nxt;
            r_pend_div <= w_pend_div_nxt;
        end
    end

    // Next-state decision; off requests take priority over new notes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_valid) w_state_nxt = PLAY;
            end
            PLAY: begin
                if (w_off)                                    w_state_nxt = STOP;
                else if (w_valid && (i_note_div != r_cur_div)) w_state_nxt = PEND;
            end
            PEND: begin
                if (w_off)       w_state_nxt = STOP;
                else if (w_term) w_state_nxt = PLAY;
            end
            STOP: begin
                if (w_valid)              w_state_nxt = PEND;
                else if (w_term && r_spk) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for speaker, sounding divisor and pending divisor.
    always_comb begin
        w_spk_nxt      = r_spk;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;
        case (r_state)
            IDLE: begin
                w_spk_nxt      = w_valid;
                w_cur_div_nxt  = w_valid ? i_note_div : '0;
                w_pend_div_nxt = '0;
            end
            PLAY: begin
                if (w_term) w_spk_nxt = !r_spk;
                if (!w_off && w_valid && (i_note_div != r_cur_div)) begin
                    w_pend_div_nxt = i_note_div;
                end
            end
            PEND: begin
                if (w_term) w_spk_nxt = !r_spk;
                if (w_off) begin
                    w_pend_div_nxt = '0;
                end else if (w_term) begin
                    w_cur_div_nxt  = w_valid ? i_note_div : r_pend_div;
                    w_pend_div_nxt = '0;
                end else if (w_valid) begin
                    w_pend_div_nxt = i_note_div;
                end
            end
            STOP: begin
                if (w_term) w_spk_nxt = !r_spk;
                if (w_valid) begin
                    w_pend_div_nxt = i_note_div;
                end else if (w_term && r_spk) begin
                    w_cur_div_nxt = '0;
                end
            end
            default: begin
                w_spk_nxt      = 1'b0;
                w_cur_div_nxt  = '0;
                w_pend_div_nxt = '0;
            end
        endcase
    end

    assign o_spk     = r_spk;
    assign o_busy    = r_busy;
    assign o_cur_div = r_cur_div;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen (default build, auto-release disabled).
module tb_tone_gen;
    import tone_gen_pkg::*;

    localparam int unsigned DW = DIV_W_DEF;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          nv    = 1'b0;
    logic          noff  = 1'b0;
    logic [DW-1:0] nd    = '0;
    logic          spk;
    logic          busy;
    logic [DW-1:0] cur;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_gen #(
        .DIV_W (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_note_div   (nd),
        .i_note_valid (nv),
        .i_note_off   (noff),
        .o_spk        (spk),
        .o_busy       (busy),
        .o_cur_div    (cur)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic s, input logic b, input logic [31:0] c);
        chk({tag, ".spk"},  32'(spk),  32'(s));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".cur"},  32'(cur),  c);
    endtask

    task automatic strobe(input logic [DW-1:0] div, input logic off);
        nv   = 1'b1;
        nd   = div;
        noff = off;
        step(1);
        nv   = 1'b0;
        noff = 1'b0;
    endtask

    initial begin
        // reset
        step(2);
        chk3("reset", 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(1);

        // start div=20: spk high next cycle, toggles every 20
        strobe(20'd20, 1'b0);
        chk3("start20", 1'b1, 1'b1, 32'd20);
        step(19); chk3("hi20_end", 1'b1, 1'b1, 32'd20);
        step(1);  chk3("lo20_start", 1'b0, 1'b1, 32'd20);
        step(19); chk3("lo20_end", 1'b0, 1'b1, 32'd20);
        step(1);  chk3("hi20_again", 1'b1, 1'b1, 32'd20);

        // pitch change mid-phase: waits for terminal, then 30-cycle halves
        step(5);
        strobe(20'd30, 1'b0);
        chk3("pend", 1'b1, 1'b1, 32'd20);
        step(13); chk3("pend_hold", 1'b1, 1'b1, 32'd20);
        step(1);  chk3("switch30", 1'b0, 1'b1, 32'd30);
        step(29); chk3("lo30_end", 1'b0, 1'b1, 32'd30);
        step(1);  chk3("hi30", 1'b1, 1'b1, 32'd30);

        // release during low phase: low completes, one full high, then idle
        step(30); chk3("lo30_b", 1'b0, 1'b1, 32'd30);
        step(5);
        strobe('0, 1'b1);
        chk3("stop_lo", 1'b0, 1'b1, 32'd30);
        step(23); chk3("stop_lo_end", 1'b0, 1'b1, 32'd30);
        step(1);  chk3("stop_last_hi", 1'b1, 1'b1, 32'd30);
        step(29); chk3("stop_hi_end", 1'b1, 1'b1, 32'd30);
        step(1);  chk3("stop_idle", 1'b0, 1'b0, 32'd0);

        // idle: low divisor and note_off are ignored
        strobe(20'd10, 1'b0);
        chk3("idle_lowdiv", 1'b0, 1'b0, 32'd0);
        strobe('0, 1'b1);
        chk3("idle_off", 1'b0, 1'b0, 32'd0);
        step(3);  chk3("idle_quiet", 1'b0, 1'b0, 32'd0);

        // valid + off same cycle: off wins, no pitch change
        strobe(20'd20, 1'b0);
        chk3("start20_b", 1'b1, 1'b1, 32'd20);
        step(3);
        strobe(20'd40, 1'b1);
        step(15); chk3("offwin_hi", 1'b1, 1'b1, 32'd20);
        step(1);  chk3("offwin_idle", 1'b0, 1'b0, 32'd0);

        // same-divisor repeat does not reset phase
        strobe(20'd20, 1'b0);
        step(10);
        strobe(20'd20, 1'b0);
        chk3("repeat", 1'b1, 1'b1, 32'd20);
        step(8);  chk3("repeat_hi_end", 1'b1, 1'b1, 32'd20);
        step(1);  chk3("repeat_lo", 1'b0, 1'b1, 32'd20);

        // switch to 50, then reset mid high phase
        strobe(20'd50, 1'b0);
        chk3("pend50", 1'b0, 1'b1, 32'd20);
        step(19); chk3("switch50", 1'b1, 1'b1, 32'd50);
        step(10);
        rst_n = 1'b0;
        step(1);  chk3("rst_mid", 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(60); chk3("rst_quiet", 1'b0, 1'b0, 32'd0);

        // boundary: div=MIN_DIV plays; div=MIN_DIV-1 while playing releases
        strobe(20'd16, 1'b0);
        chk3("min_div", 1'b1, 1'b1, 32'd16);
        step(15); chk3("min_hi_end", 1'b1, 1'b1, 32'd16);
        step(1);  chk3("min_lo", 1'b0, 1'b1, 32'd16);
        strobe(20'd15, 1'b0);
        chk3("low_off", 1'b0, 1'b1, 32'd16);
        step(15); chk3("low_off_hi", 1'b1, 1'b1, 32'd16);
        step(15); chk3("low_off_hi_end", 1'b1, 1'b1, 32'd16);
        step(1);  chk3("low_off_idle", 1'b0, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
